// File: rtl/ppu_spr_eval.sv
// rtl/ppu_spr_eval.sv - PPU sprite evaluation: clears secondary OAM, then copies up to
// MAX_SLOTS in-range primary-OAM sprites into it and flags sprite overflow / sprite 0.
module ppu_spr_eval #(
  parameter int MAX_SLOTS      = 8,
  parameter int CLEAR_END_DOT  = 32,
  parameter int EVAL_START_DOT = 65,
  parameter int EVAL_END_DOT   = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_idx,
  input  logic [9:0] scanline,
  input  logic       rendering_en,
  input  logic       spr_size,
  output logic [7:0] oam_addr,
  input  logic [7:0] oam_data_in,
  output logic       soam_we,
  output logic [4:0] soam_addr,
  output logic [7:0] soam_data,
  output logic [3:0] spr_count,
  output logic       spr0_in_range,
  output logic       spr_overflow,
  output logic       eval_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT, S_CHECK, S_COPY, S_DONE
  } state_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_SLOTS);

  state_e     state_q, state_d;
  logic [5:0] n_q, n_d;
  logic [1:0] m_q, m_d;
  logic [3:0] cnt_q, cnt_d;
  logic       spr0_q, spr0_d;
  logic       ovf_q, ovf_d;
  logic       done_q, done_d;

  logic       active;
  logic       ovf_clr;
  logic       in_range;
  logic       hard_stop;
  logic [8:0] diff;
  logic [9:0] clr_addr;

  assign active    = rendering_en && (scanline <= 10'd239);
  assign ovf_clr   = (scanline == 10'd261) && (x_idx == 10'd1);
  assign hard_stop = (x_idx == 10'(EVAL_END_DOT));
  assign diff      = {1'b0, scanline[7:0]} - {1'b0, oam_data_in};
  assign in_range  = !diff[8] && (diff < (spr_size ? 9'd16 : 9'd8));
  assign clr_addr  = x_idx - 10'd1;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    spr0_d    = spr0_q;
    ovf_d     = ovf_q;
    done_d    = done_q;
    oam_addr  = 8'h00;
    soam_we   = 1'b0;
    soam_addr = 5'd0;
    soam_data = 8'h00;

    if (ovf_clr) ovf_d = 1'b0;

    if (!active) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (x_idx == 10'd0) begin
            state_d = S_CLEAR;
            cnt_d   = 4'd0;
            spr0_d  = 1'b0;
            done_d  = 1'b0;
          end
        end
        S_CLEAR: begin
          soam_we   = 1'b1;
          soam_addr = clr_addr[4:0];
          soam_data = 8'hFF;
          if (x_idx == 10'(CLEAR_END_DOT)) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (x_idx == 10'(EVAL_START_DOT - 1)) begin
            n_d     = 6'd0;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (hard_stop) begin
            state_d = S_DONE;
          end else if (in_range && (cnt_q < MAX_CNT)) begin
            soam_we   = 1'b1;
            soam_addr = {cnt_q[2:0], 2'b00};
            soam_data = oam_data_in;
            oam_addr  = {n_q, 2'b01};
            m_d       = 2'd1;
            state_d   = S_COPY;
          end else if (in_range) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else if (n_q == 6'd63) begin
            state_d = S_DONE;
          end else begin
            n_d      = n_q + 6'd1;
            oam_addr = {n_q + 6'd1, 2'b00};
          end
        end
        S_COPY: begin
          if (hard_stop) begin
            state_d = S_DONE;
          end else begin
            soam_we   = 1'b1;
            soam_addr = {cnt_q[2:0], m_q};
            soam_data = oam_data_in;
            if (m_q != 2'd3) begin
              oam_addr = {n_q, m_q + 2'd1};
              m_d      = m_q + 2'd1;
            end else begin
              cnt_d = cnt_q + 4'd1;
              if (n_q == 6'd0) spr0_d = 1'b1;
              if (n_q == 6'd63) begin
                state_d = S_DONE;
              end else begin
                n_d      = n_q + 6'd1;
                oam_addr = {n_q + 6'd1, 2'b00};
                state_d  = S_CHECK;
              end
            end
          end
        end
        S_DONE: begin
          if (x_idx == 10'd340) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_DONE) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= 6'd0;
      m_q     <= 2'd0;
      cnt_q   <= 4'd0;
      spr0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      spr0_q  <= spr0_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Mask the sticky flag on the clearing dot itself so it reads 0 from dot 1 of line 261.
  assign spr_overflow  = ovf_q && !ovf_clr;
  assign spr_count     = cnt_q;
  assign spr0_in_range = spr0_q;
  assign eval_done     = done_q;

endmodule

// File: tb/tb_ppu_spr_eval.sv
// tb/tb_ppu_spr_eval.sv - table-driven and randomized bench for ppu_spr_eval
// against a per-line reference model of sprite selection and write timing.
module tb_ppu_spr_eval;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_idx, scanline;
  logic       rendering_en, spr_size;
  logic [7:0] oam_addr, oam_rd;
  logic       soam_we;
  logic [4:0] soam_addr;
  logic [7:0] soam_data;
  logic [3:0] spr_count;
  logic       spr0_in_range, spr_overflow, eval_done;

  ppu_spr_eval dut (
    .clk(clk), .reset(reset), .x_idx(x_idx), .scanline(scanline),
    .rendering_en(rendering_en), .spr_size(spr_size),
    .oam_addr(oam_addr), .oam_data_in(oam_rd),
    .soam_we(soam_we), .soam_addr(soam_addr), .soam_data(soam_data),
    .spr_count(spr_count), .spr0_in_range(spr0_in_range),
    .spr_overflow(spr_overflow), .eval_done(eval_done)
  );

  always #5 clk = ~clk;

  logic [7:0] oam_mem [256];
  logic [7:0] soam_mir [32];
  always @(posedge clk) oam_rd <= oam_mem[oam_addr];

  typedef struct packed {
    int         dot;
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];

  typedef struct {
    int kind; int sl; bit sz; int cnt; bit s0; bit ovf;
  } vec_t;
  vec_t vecs[6];

  int n_pass = 0, n_total = 0;
  int s_cnt, late;
  bit s_s0, s_ovf, s_done, s_nz, s_rst_we;
  logic [28:0] s_rst;
  bit ovf_tr [341];
  bit ovf_model;
  int m_cnt;
  bit m_s0, m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_line(input int sl, input bit en, input bit sz, input int rst_dot);
    got_q.delete();
    s_nz = 0;
    late = 0;
    for (int x = 0; x <= 340; x++) begin
      x_idx = 10'(x); scanline = 10'(sl); rendering_en = en; spr_size = sz;
      reset = (x == rst_dot);
      @(negedge clk);
      if (soam_we) begin
        got_q.push_back('{x, soam_addr, soam_data});
        soam_mir[soam_addr] = soam_data;
        if (rst_dot >= 0 && x > rst_dot) late++;
      end
      if (oam_addr != 8'h00) s_nz = 1;
      ovf_tr[x] = spr_overflow;
      if (x == 300) begin
        s_cnt = int'(spr_count); s_s0 = spr0_in_range; s_ovf = spr_overflow; s_done = eval_done;
      end
      if (x == rst_dot + 1) begin
        s_rst = {oam_addr, soam_we, soam_addr, soam_data, spr_count,
                 spr0_in_range, spr_overflow, eval_done};
        s_rst_we = soam_we;
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  // Reference: which sprites land in which slots, and on which dots each byte is written.
  task automatic model_line(input int sl, input bit sz, output int cnt, output bit s0, output bit lovf);
    int t, h, y;
    exp_q.delete();
    for (int d = 1; d <= 32; d++) exp_q.push_back('{d, 5'(d - 1), 8'hFF});
    t = 65; cnt = 0; s0 = 0; lovf = 0; h = sz ? 16 : 8;
    for (int n = 0; n < 64; n++) begin
      y = int'(oam_mem[4*n]);
      if (sl >= y && sl - y < h) begin
        if (cnt < 8) begin
          for (int b = 0; b < 4; b++) exp_q.push_back('{t + b, 5'(cnt*4 + b), oam_mem[4*n + b]});
          t += 4;
          if (n == 0) s0 = 1;
          cnt++;
        end else begin
          lovf = 1;
          break;
        end
      end else begin
        t++;
      end
    end
  endtask

  task automatic cmp_log(input string pfx);
    int mism, lim;
    mism = 0;
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    chk($sformatf("%s_wr_len", pfx), got_q.size(), exp_q.size());
    for (int i = 0; i < lim; i++) if (got_q[i] != exp_q[i]) mism++;
    chk($sformatf("%s_wr_mismatches", pfx), mism, 0);
  endtask

  task automatic setup_kind(input int k);
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) oam_mem[4*i] = 8'hFF;
    case (k)
      1: begin oam_mem[0] = 8'd10; oam_mem[1] = 8'h42; oam_mem[2] = 8'h01; oam_mem[3] = 8'h80; end
      2: for (int i = 0; i < 9; i++) oam_mem[4*i] = 8'd20;
      3: oam_mem[20] = 8'd100;
      default: ;
    endcase
  endtask

  initial begin
    vecs[0] = '{0,  10, 1'b0, 0, 1'b0, 1'b0};
    vecs[1] = '{1,  12, 1'b0, 1, 1'b1, 1'b0};
    vecs[2] = '{3, 112, 1'b1, 1, 1'b0, 1'b0};
    vecs[3] = '{3, 112, 1'b0, 0, 1'b0, 1'b0};
    vecs[4] = '{3, 116, 1'b1, 0, 1'b0, 1'b0};
    vecs[5] = '{2,  25, 1'b0, 8, 1'b1, 1'b1};
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'hFF;

    reset = 1'b1; x_idx = 10'd0; scanline = 10'd261; rendering_en = 1'b1; spr_size = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_oam_addr", int'(oam_addr), 0);
    chk("rst_soam_we", int'(soam_we), 0);
    chk("rst_soam_addr", int'(soam_addr), 0);
    chk("rst_soam_data", int'(soam_data), 0);
    chk("rst_spr_count", int'(spr_count), 0);
    chk("rst_spr0", int'(spr0_in_range), 0);
    chk("rst_overflow", int'(spr_overflow), 0);
    chk("rst_eval_done", int'(eval_done), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ovf_model = 0;

    for (int v = 0; v < 6; v++) begin
      setup_kind(vecs[v].kind);
      run_line(vecs[v].sl, 1'b1, vecs[v].sz, -1);
      model_line(vecs[v].sl, vecs[v].sz, m_cnt, m_s0, m_ovf);
      ovf_model |= m_ovf;
      chk($sformatf("vec%0d_count", v), s_cnt, vecs[v].cnt);
      chk($sformatf("vec%0d_spr0", v), int'(s_s0), int'(vecs[v].s0));
      chk($sformatf("vec%0d_overflow", v), int'(s_ovf), int'(vecs[v].ovf));
      chk($sformatf("vec%0d_done", v), int'(s_done), 1);
      cmp_log($sformatf("vec%0d", v));
      if (vecs[v].kind == 1)
        chk("vec1_soam_slot0", int'({soam_mir[0], soam_mir[1], soam_mir[2], soam_mir[3]}), 32'h0A420180);
    end

    run_line(240, 1'b1, 1'b0, -1);
    chk("ovf_sticky_240", int'(s_ovf), 1);
    run_line(261, 1'b1, 1'b0, -1);
    chk("ovf_261_dot0", int'(ovf_tr[0]), 1);
    chk("ovf_261_dot1", int'(ovf_tr[1]), 0);
    chk("ovf_261_dot2", int'(ovf_tr[2]), 0);
    ovf_model = 0;

    setup_kind(0);
    oam_mem[0] = 8'd25;
    oam_mem[4] = 8'd28;
    run_line(30, 1'b1, 1'b0, 70);
    chk("midline_rst_outputs", int'(s_rst), 0);
    chk("midline_rst_soam_we", int'(s_rst_we), 0);
    chk("midline_rst_late_writes", late, 0);
    run_line(31, 1'b1, 1'b0, -1);
    model_line(31, 1'b0, m_cnt, m_s0, m_ovf);
    chk("after_rst_count", s_cnt, 2);
    chk("after_rst_spr0", int'(s_s0), 1);
    chk("after_rst_overflow", int'(s_ovf), 0);
    cmp_log("after_rst");

    run_line(50, 1'b0, 1'b0, -1);
    chk("disabled_writes", got_q.size(), 0);
    chk("disabled_oam_addr_nz", int'(s_nz), 0);
    chk("disabled_count_held", s_cnt, 2);

    for (int r = 0; r < 24; r++) begin
      int sl, yv;
      bit sz;
      sl = int'($urandom_range(0, 239));
      sz = 1'($urandom);
      for (int i = 0; i < 256; i++) oam_mem[i] = 8'($urandom);
      for (int i = 0; i < 64; i++) begin
        yv = sl - int'($urandom_range(0, 24)) + 4;
        if (yv < 0) yv = 255;
        if ($urandom_range(0, 3) == 0) yv = int'($urandom_range(0, 255));
        oam_mem[4*i] = 8'(yv);
      end
      run_line(sl, 1'b1, sz, -1);
      model_line(sl, sz, m_cnt, m_s0, m_ovf);
      ovf_model |= m_ovf;
      chk($sformatf("rnd%0d_count", r), s_cnt, m_cnt);
      chk($sformatf("rnd%0d_spr0", r), int'(s_s0), int'(m_s0));
      chk($sformatf("rnd%0d_overflow", r), int'(s_ovf), int'(ovf_model));
      chk($sformatf("rnd%0d_done", r), int'(s_done), 1);
      cmp_log($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
